fifo2gmii_tx: RTL
=================

// Module: fifo2gmii_tx
// PURPOSE
//  Transmit side of the video-over-UDP link. On a start request, drains one line segment of
//  16-bit pixels from a first-word-fall-through FIFO and emits one complete GMII frame:
//  preamble/SFD, Ethernet II, IPv4, UDP, a 3-byte packet-info header and the pixel payload,
//  followed by the FCS. Sits between the capture-side line FIFO and the GMII TX pins.
// PARAMETERS
//  eth_dst      48'hFFFFFFFFFFFF                destination MAC
//  eth_src      48'h001122334455                source MAC
//  ipv4_src     {8'd192,8'd168,8'd0,8'd2}       IPv4 source address
//  ipv4_dst     {8'd192,8'd168,8'd0,8'd1}       IPv4 destination base; last octet gets +id
//  src_port     16'd12345                       UDP source port
//  dst_port     16'd12345                       UDP destination port
//  DATA_BYTES   1280                            payload pixel bytes per frame (even, <=1440)
//  IFG          12                              idle cycles after the FCS
// PORTS
//  clk125      in   1   125 MHz GMII TX clock
//  sys_rst     in   1   asynchronous active-high reset
//  id          in   1   added to the last octet of ipv4_dst
//  tx_start    in   1   frame request; sampled only in IDLE
//  y_info      in   12  line number; latched on an accepted tx_start
//  x_info      in   4   segment index; latched on an accepted tx_start
//  fifo_dout   in   16  FWFT FIFO head word {hi byte, lo byte}
//  fifo_empty  in   1   FIFO empty
//  fifo_rd_en  out  1   pops the FIFO head
//  txd         out  8   GMII TX data
//  tx_en       out  1   GMII TX enable
//  busy        out  1   high from an accepted tx_start to the end of IFG
//  done        out  1   1-cycle pulse in the last IFG cycle
//  underrun    out  1   1-cycle pulse for each pixel substituted because the FIFO was empty
// BEHAVIOUR
//  - Reset: all outputs 0 and state IDLE, applied asynchronously, including mid-frame
//    (tx_en drops at once; the frame is truncated and not resumed).
//  - FSM: IDLE -> PRE(8) -> HDR(42) -> INFO(3) -> DATA(DATA_BYTES) -> FCS(4) -> GAP(IFG) -> IDLE.
//    The transition into IDLE happens on the cycle after done.
//  - Latency: tx_start is accepted in IDLE. On the next edge tx_en=1 and txd=8'h55. tx_start
//    while busy is ignored. tx_start still high in IDLE immediately starts the next frame.
//  - Frame byte indices (byte 0 = first preamble byte):
//      0-6   8'h55
//      7     8'hD5
//      8-13  eth_dst
//      14-19 eth_src
//      20-21 16'h0800
//      22    8'h45
//      23    8'h00
//      24-25 IP total length = 31+DATA_BYTES
//      26-27 16'h0000
//      28-29 16'h4000
//      30    8'h40 (TTL)
//      31    8'h11
//      32-33 header checksum
//      34-37 ipv4_src
//      38-41 ipv4_dst, last octet = ipv4_dst[7:0]+id (8-bit wrap)
//      42-43 src_port
//      44-45 dst_port
//      46-47 UDP length = 11+DATA_BYTES
//      48-49 16'h0000 (UDP checksum disabled)
//      50    8'h00 (video packet-info)
//      51    y_info[7:0]
//      52    {x_info, y_info[11:8]}
//      53+   pixels, hi byte first
//  - All multi-byte fields are sent MSB first.
//  - IP checksum: 16-bit ones'-complement sum of the ten header words, with end-around carry,
//    then inverted. It is accumulated sequentially during PRE and is stable before byte 32.
//  - DATA: on a hi-byte cycle, send fifo_dout[15:8]. On a lo-byte cycle, send fifo_dout[7:0] and
//    assert fifo_rd_en only if fifo_empty=0. If fifo_empty=1 on the hi-byte cycle, both bytes
//    of that pixel are 8'h00, underrun pulses once, and nothing is popped.
//    Frame length never changes.
//  - FCS: CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF, final inverted) over bytes 8 through
//    the last payload byte. Sent low byte first, 1 byte per cycle.
//  - tx_en is high exactly for PRE..FCS: 57+DATA_BYTES cycles.
//    txd=0 whenever tx_en=0; fifo_rd_en=0 outside DATA.
// TESTING
//  1 FIFO holds 640 words 0x0000..0x027F; DATA_BYTES=1280, y_info=12'h123, x_info=4'h5, id=0,
//    one tx_start -> tx_en high for 1337 cycles; bytes 20,21 = 08,00; byte 50=00, 51=23, 52=51;
//    bytes 53,54 = 00,00; last pixel = 02,7F; 640 pops; FCS matches a software CRC model.
//  2 id=1 -> byte 41 = 8'h02; software recompute of the IP header checksum over bytes 22-41 = 16'h0000.
//  3 fifo_empty forced to 1 after 100 pops -> remaining 1080 payload bytes are 00;
//    540 underrun pulses; tx_en length is still 1337.
//  4 tx_start held high -> done pulses; the second preamble starts exactly IFG+1 cycles
//    after the last FCS byte.
//  5 sys_rst asserted at payload byte 300 -> tx_en, fifo_rd_en and busy are 0 before the next
//    edge; after release the block idles until tx_start.
//  6 tx_start pulsed during HDR -> ignored; exactly one frame; busy drops after GAP.

Source files
------------

// File: rtl/fifo2gmii_tx_if.sv
// ----------------------------------------------------------------------------
// fifo2gmii_tx_if
//   Bundles the request/status, FWFT FIFO and GMII TX signals of the
//   video-over-UDP transmitter so that they travel as one port.
//   slave  : transmitter view (requests/FIFO head in, GMII/status/pop out)
//   master : environment view (drives requests and FIFO head, observes the rest)
// Signals
//   id, tx_start, y_info[11:0], x_info[3:0]   frame request and line/segment tags
//   fifo_dout[15:0], fifo_empty, fifo_rd_en   first-word-fall-through FIFO
//   txd[7:0], tx_en                           GMII transmit
//   busy, done, underrun                      status
// ----------------------------------------------------------------------------
interface fifo2gmii_tx_if;
  logic        id;
  logic        tx_start;
  logic [11:0] y_info;
  logic [3:0]  x_info;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  txd;
  logic        tx_en;
  logic        busy;
  logic        done;
  logic        underrun;

  modport slave (
    input  id, tx_start, y_info, x_info, fifo_dout, fifo_empty,
    output fifo_rd_en, txd, tx_en, busy, done, underrun
  );

  modport master (
    output id, tx_start, y_info, x_info, fifo_dout, fifo_empty,
    input  fifo_rd_en, txd, tx_en, busy, done, underrun
  );
endinterface

// File: rtl/fifo2gmii_tx.sv
// ----------------------------------------------------------------------------
// fifo2gmii_tx
//   Transmit side of the video-over-UDP link. On an accepted start request it
//   drains one line segment of 16-bit pixels from a FWFT FIFO and sends one
//   GMII frame: preamble/SFD, Ethernet II, IPv4, UDP, 3-byte packet info,
//   pixel payload (hi byte first) and the CRC-32 FCS, then an inter-frame gap.
// Ports
//   clk125  : 125 MHz GMII TX clock
//   sys_rst : asynchronous active-high reset (truncates a frame in flight)
//   bus     : fifo2gmii_tx_if.slave - request, FIFO and GMII/status signals
// ----------------------------------------------------------------------------
module fifo2gmii_tx #(
  parameter logic [47:0] eth_dst    = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] eth_src    = 48'h001122334455,
  parameter logic [31:0] ipv4_src   = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [31:0] ipv4_dst   = {8'd192, 8'd168, 8'd0, 8'd1},
  parameter logic [15:0] src_port   = 16'd12345,
  parameter logic [15:0] dst_port   = 16'd12345,
  parameter int          DATA_BYTES = 1280,
  parameter int          IFG        = 12
) (
  input  logic         clk125,
  input  logic         sys_rst,
  fifo2gmii_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_INFO, S_DATA, S_FCS, S_GAP
  } state_t;

  localparam logic [15:0] IP_LEN    = 16'(31 + DATA_BYTES);
  localparam logic [15:0] UDP_LEN   = 16'(11 + DATA_BYTES);
  localparam logic [10:0] DATA_LAST = 11'(DATA_BYTES - 1);
  localparam logic [10:0] GAP_LAST  = 11'(IFG - 1);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;       // byte counter within the current state
  logic        hole_q, hole_d;     // current pixel was substituted (FIFO empty on hi byte)

  logic [11:0] y_q;
  logic [3:0]  x_q;
  logic        id_q;
  logic [19:0] csum_q;             // unfolded IPv4 header sum, folded during the preamble
  logic [31:0] crc_q;

  logic [7:0]  txd_c;
  logic        tx_en_c, rd_en_c, und_c, done_c;
  logic [7:0]  last_oct;
  logic [15:0] ip_csum;
  logic [31:0] fcs;

  assign last_oct = ipv4_dst[7:0] + {7'd0, id_q};
  assign ip_csum  = ~csum_q[15:0];
  assign fcs      = ~crc_q;

  // Reflected CRC-32 (poly 04C11DB7) advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // The ten IPv4 header words; word 5 is the checksum field itself, summed as 0.
  function automatic logic [15:0] ip_word(input logic [3:0] k, input logic [7:0] lo);
    case (k)
      4'd0:    return 16'h4500;
      4'd1:    return IP_LEN;
      4'd3:    return 16'h4000;
      4'd4:    return 16'h4011;
      4'd6:    return ipv4_src[31:16];
      4'd7:    return ipv4_src[15:0];
      4'd8:    return ipv4_dst[31:16];
      4'd9:    return {ipv4_dst[15:8], lo};
      default: return 16'h0000;
    endcase
  endfunction

  // Header byte idx counts from the first destination-MAC byte (frame byte 8).
  function automatic logic [7:0] hdr_byte(input logic [5:0] idx, input logic [15:0] ck,
                                          input logic [7:0] lo);
    int         i;
    logic [7:0] b;
    i = int'(idx);
    b = 8'h00;
    if (i < 6)
      b = eth_dst[8*(5-i) +: 8];
    else if (i < 12)
      b = eth_src[8*(11-i) +: 8];
    else
      case (i)
        12:      b = 8'h08;
        14:      b = 8'h45;
        16:      b = IP_LEN[15:8];
        17:      b = IP_LEN[7:0];
        20:      b = 8'h40;
        22:      b = 8'h40;
        23:      b = 8'h11;
        24:      b = ck[15:8];
        25:      b = ck[7:0];
        26:      b = ipv4_src[31:24];
        27:      b = ipv4_src[23:16];
        28:      b = ipv4_src[15:8];
        29:      b = ipv4_src[7:0];
        30:      b = ipv4_dst[31:24];
        31:      b = ipv4_dst[23:16];
        32:      b = ipv4_dst[15:8];
        33:      b = lo;
        34:      b = src_port[15:8];
        35:      b = src_port[7:0];
        36:      b = dst_port[15:8];
        37:      b = dst_port[7:0];
        38:      b = UDP_LEN[15:8];
        39:      b = UDP_LEN[7:0];
        default: b = 8'h00;
      endcase
    return b;
  endfunction

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hole_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hole_q  <= hole_d;
    end
  end

  // Frame context: re-initialised on every accepted start, so no reset needed.
  always_ff @(posedge clk125) begin
    if (state_q == S_IDLE && bus.tx_start) begin
      y_q    <= bus.y_info;
      x_q    <= bus.x_info;
      id_q   <= bus.id;
      csum_q <= '0;
      crc_q  <= 32'hFFFFFFFF;
    end
    // Preamble cycles 0-4 add two header words each; later cycles fold the carries.
    if (state_q == S_PRE) begin
      if (cnt_q < 11'd5)
        csum_q <= csum_q + {4'h0, ip_word({cnt_q[2:0], 1'b0}, last_oct)}
                         + {4'h0, ip_word({cnt_q[2:0], 1'b1}, last_oct)};
      else
        csum_q <= {4'h0, csum_q[15:0]} + {16'h0, csum_q[19:16]};
    end
    if (state_q inside {S_HDR, S_INFO, S_DATA})
      crc_q <= crc_byte(crc_q, txd_c);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    hole_d  = hole_q;
    txd_c   = 8'h00;
    tx_en_c = 1'b0;
    rd_en_c = 1'b0;
    und_c   = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.tx_start) state_d = S_PRE;
      end
      S_PRE: begin
        tx_en_c = 1'b1;
        txd_c   = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
        if (cnt_q == 11'd7) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
      S_HDR: begin
        tx_en_c = 1'b1;
        txd_c   = hdr_byte(cnt_q[5:0], ip_csum, last_oct);
        if (cnt_q == 11'd41) begin
          state_d = S_INFO;
          cnt_d   = '0;
        end
      end
      S_INFO: begin
        tx_en_c = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_c = 8'h00;
          2'd1:    txd_c = y_q[7:0];
          default: txd_c = {x_q, y_q[11:8]};
        endcase
        if (cnt_q == 11'd2) begin
          state_d = S_DATA;
          cnt_d   = '0;
          hole_d  = 1'b0;
        end
      end
      S_DATA: begin
        tx_en_c = 1'b1;
        if (!cnt_q[0]) begin
          // Hi byte decides for the whole pixel; a hole keeps the frame length fixed.
          hole_d = bus.fifo_empty;
          und_c  = bus.fifo_empty;
          txd_c  = bus.fifo_empty ? 8'h00 : bus.fifo_dout[15:8];
        end else begin
          txd_c   = hole_q ? 8'h00 : bus.fifo_dout[7:0];
          rd_en_c = !hole_q && !bus.fifo_empty;
        end
        if (cnt_q == DATA_LAST) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: begin
        tx_en_c = 1'b1;
        case (cnt_q[1:0])
          2'd0:    txd_c = fcs[7:0];
          2'd1:    txd_c = fcs[15:8];
          2'd2:    txd_c = fcs[23:16];
          default: txd_c = fcs[31:24];
        endcase
        if (cnt_q == 11'd3) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.txd        = txd_c;
  assign bus.tx_en      = tx_en_c;
  assign bus.fifo_rd_en = rd_en_c;
  assign bus.underrun   = und_c;
  assign bus.done       = done_c;
  assign bus.busy       = (state_q != S_IDLE);

endmodule
